// File: rtl/pipelined_dot_accumulator_if.sv
// Product-stream and dot-product result bundle for pipelined_dot_accumulator.
// The master drives products and clear. The slave (the accumulator) returns results.
interface dot_acc_if #(
  parameter int PRODUCT_WIDTH = 12,
  parameter int ACC_WIDTH     = 20,
  parameter int CNT_WIDTH     = 8
);
  logic [PRODUCT_WIDTH-1:0] product_in;
  logic                     product_valid;
  logic                     clear;
  logic [ACC_WIDTH-1:0]     sum_out;
  logic                     sum_valid;
  logic [CNT_WIDTH-1:0]     element_count;
  logic                     overflow;

  modport master (
    output product_in, product_valid, clear,
    input  sum_out, sum_valid, element_count, overflow
  );

  modport slave (
    input  product_in, product_valid, clear,
    output sum_out, sum_valid, element_count, overflow
  );
endinterface

// File: rtl/pipelined_dot_accumulator.sv
// Sums VECTOR_LEN consecutive valid products into one registered dot-product result.
// Optional macro DOT_ACC_SATURATE_EN: clamp on overflow and raise a sticky overflow flag.
module pipelined_dot_accumulator #(
  parameter int PRODUCT_WIDTH = 12,
  parameter int VECTOR_LEN    = 256,
  parameter int ACC_WIDTH     = PRODUCT_WIDTH + $clog2(VECTOR_LEN),
  parameter int CNT_WIDTH     = $clog2(VECTOR_LEN)
) (
  input logic      clk,
  input logic      reset,
  dot_acc_if.slave bus
);
  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(VECTOR_LEN - 1);

  state_t               state, state_nxt;
  logic [ACC_WIDTH-1:0] acc, acc_nxt;
  logic [ACC_WIDTH-1:0] sum_q, sum_nxt;
  logic [CNT_WIDTH-1:0] count, count_nxt;
  logic                 sum_valid_q, sum_valid_nxt;
  logic                 ovf_q, ovf_nxt;

  logic [ACC_WIDTH-1:0] addend;
  logic [ACC_WIDTH-1:0] sum_add;
  logic                 add_ovf;

  assign addend = ACC_WIDTH'(bus.product_in);

`ifdef DOT_ACC_SATURATE_EN
  logic [ACC_WIDTH:0] sum_wide;

  // Carry out of the widened add is the overflow condition; clamp to all-ones.
  always_comb begin
    sum_wide = {1'b0, acc} + {1'b0, addend};
    add_ovf  = sum_wide[ACC_WIDTH];
    sum_add  = add_ovf ? '1 : sum_wide[ACC_WIDTH-1:0];
  end
`else
  always_comb begin
    sum_add = acc + addend;
    add_ovf = 1'b0;
  end
`endif

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    count_nxt     = count;
    sum_nxt       = sum_q;
    sum_valid_nxt = 1'b0;
    ovf_nxt       = ovf_q;

    if (bus.clear) begin
      // Abort discards any product sampled alongside clear; sum_out is kept.
      state_nxt = IDLE;
      acc_nxt   = '0;
      count_nxt = '0;
      ovf_nxt   = 1'b0;
    end else if (bus.product_valid) begin
      unique case (state)
        IDLE: begin
          acc_nxt   = addend;
          count_nxt = CNT_WIDTH'(1);
          ovf_nxt   = 1'b0;
          state_nxt = ACCUM;
        end
        ACCUM: begin
          if (add_ovf) ovf_nxt = 1'b1;
          if (count == LAST_IDX) begin
            sum_nxt       = sum_add;
            sum_valid_nxt = 1'b1;
            acc_nxt       = '0;
            count_nxt     = '0;
            state_nxt     = IDLE;
          end else begin
            acc_nxt   = sum_add;
            count_nxt = count + CNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      count       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      acc         <= acc_nxt;
      count       <= count_nxt;
      sum_q       <= sum_nxt;
      sum_valid_q <= sum_valid_nxt;
      ovf_q       <= ovf_nxt;
    end
  end

  assign bus.sum_out       = sum_q;
  assign bus.sum_valid     = sum_valid_q;
  assign bus.element_count = count;
  assign bus.overflow      = ovf_q;
endmodule

// File: tb/tb_pipelined_dot_accumulator.sv
// Directed bench for pipelined_dot_accumulator: a VECTOR_LEN=4 instance for the
// main scenarios and a 12-bit, VECTOR_LEN=2 instance for the overflow case.
module tb_pipelined_dot_accumulator;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

`ifdef DOT_ACC_SATURATE_EN
  localparam logic [11:0] EXP_OVF_SUM  = 12'd4095;
  localparam logic        EXP_OVF_FLAG = 1'b1;
`else
  localparam logic [11:0] EXP_OVF_SUM  = 12'd1904;
  localparam logic        EXP_OVF_FLAG = 1'b0;
`endif

  dot_acc_if #(.PRODUCT_WIDTH(12), .ACC_WIDTH(14), .CNT_WIDTH(2)) bus4 ();
  dot_acc_if #(.PRODUCT_WIDTH(12), .ACC_WIDTH(12), .CNT_WIDTH(1)) bus2 ();

  pipelined_dot_accumulator #(.PRODUCT_WIDTH(12), .VECTOR_LEN(4)) dut4 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus4.slave)
  );

  pipelined_dot_accumulator #(.PRODUCT_WIDTH(12), .VECTOR_LEN(2), .ACC_WIDTH(12)) dut2 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [11:0] p);
    bus4.product_in    = p;
    bus4.product_valid = 1'b1;
    tick();
    bus4.product_valid = 1'b0;
  endtask

  task automatic send2(input logic [11:0] p);
    bus2.product_in    = p;
    bus2.product_valid = 1'b1;
    tick();
    bus2.product_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (bus4.sum_out !== 14'd0 || bus4.sum_valid !== 1'b0 ||
        bus4.element_count !== 2'd0 || bus4.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state4: sum=%0d valid=%b cnt=%0d ovf=%b, expected all 0",
               bus4.sum_out, bus4.sum_valid, bus4.element_count, bus4.overflow);
    end
    checks++;
    if (bus2.sum_out !== 12'd0 || bus2.sum_valid !== 1'b0 ||
        bus2.element_count !== 1'd0 || bus2.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state2: sum=%0d valid=%b cnt=%0d ovf=%b, expected all 0",
               bus2.sum_out, bus2.sum_valid, bus2.element_count, bus2.overflow);
    end
  endtask

  task automatic test_contiguous();
    send4(12'd14);
    send4(12'd8);
    send4(12'd18);
    checks++;
    if (bus4.element_count !== 2'd3 || bus4.sum_valid !== 1'b0) begin
      errors++;
      $display("FAIL contig_pre_last: cnt=%0d valid=%b, expected cnt=3 valid=0",
               bus4.element_count, bus4.sum_valid);
    end
    send4(12'd21);
    checks++;
    if (bus4.sum_valid !== 1'b1 || bus4.sum_out !== 14'd61 || bus4.element_count !== 2'd0) begin
      errors++;
      $display("FAIL contig_result: valid=%b sum=%0d cnt=%0d, expected valid=1 sum=61 cnt=0",
               bus4.sum_valid, bus4.sum_out, bus4.element_count);
    end
    tick();
    checks++;
    if (bus4.sum_valid !== 1'b0 || bus4.sum_out !== 14'd61) begin
      errors++;
      $display("FAIL contig_hold: valid=%b sum=%0d, expected valid=0 sum=61",
               bus4.sum_valid, bus4.sum_out);
    end
  endtask

  task automatic test_gaps();
    send4(12'd14);
    send4(12'd8);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus4.element_count !== 2'd2 || bus4.sum_valid !== 1'b0) begin
        errors++;
        $display("FAIL gap_hold[%0d]: cnt=%0d valid=%b, expected cnt=2 valid=0",
                 i, bus4.element_count, bus4.sum_valid);
      end
    end
    send4(12'd18);
    send4(12'd21);
    checks++;
    if (bus4.sum_valid !== 1'b1 || bus4.sum_out !== 14'd61) begin
      errors++;
      $display("FAIL gap_result: valid=%b sum=%0d, expected valid=1 sum=61",
               bus4.sum_valid, bus4.sum_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] vec [8];
    vec = '{12'd14, 12'd8, 12'd18, 12'd21, 12'd3000, 12'd1, 12'd1, 12'd1};
    bus4.product_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus4.product_in = vec[i];
      tick();
      checks++;
      if (i == 3) begin
        if (bus4.sum_valid !== 1'b1 || bus4.sum_out !== 14'd61) begin
          errors++;
          $display("FAIL b2b_first: valid=%b sum=%0d, expected valid=1 sum=61",
                   bus4.sum_valid, bus4.sum_out);
        end
      end else if (i == 7) begin
        if (bus4.sum_valid !== 1'b1 || bus4.sum_out !== 14'd3003) begin
          errors++;
          $display("FAIL b2b_second: valid=%b sum=%0d, expected valid=1 sum=3003",
                   bus4.sum_valid, bus4.sum_out);
        end
      end else begin
        if (bus4.sum_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_no_strobe[%0d]: valid=%b, expected 0", i, bus4.sum_valid);
        end
      end
    end
    bus4.product_valid = 1'b0;
    tick();
    checks++;
    if (bus4.sum_valid !== 1'b0 || bus4.element_count !== 2'd0) begin
      errors++;
      $display("FAIL b2b_after: valid=%b cnt=%0d, expected valid=0 cnt=0",
               bus4.sum_valid, bus4.element_count);
    end
  endtask

  task automatic test_clear();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    send4(12'd14);
    send4(12'd8);
    bus4.clear = 1'b1;
    send4(12'd18);
    bus4.clear = 1'b0;
    checks++;
    if (bus4.element_count !== 2'd0 || bus4.sum_valid !== 1'b0 || bus4.sum_out !== 14'd0) begin
      errors++;
      $display("FAIL clear_abort: cnt=%0d valid=%b sum=%0d, expected cnt=0 valid=0 sum=0",
               bus4.element_count, bus4.sum_valid, bus4.sum_out);
    end
    for (int i = 1; i <= 3; i++) begin
      send4(12'(i));
      checks++;
      if (bus4.sum_out !== 14'd0 || bus4.element_count !== 2'(i)) begin
        errors++;
        $display("FAIL clear_partial[%0d]: sum=%0d cnt=%0d, expected sum=0 cnt=%0d",
                 i, bus4.sum_out, bus4.element_count, i);
      end
    end
    send4(12'd4);
    checks++;
    if (bus4.sum_valid !== 1'b1 || bus4.sum_out !== 14'd10) begin
      errors++;
      $display("FAIL clear_result: valid=%b sum=%0d, expected valid=1 sum=10",
               bus4.sum_valid, bus4.sum_out);
    end
    // Clear on the last-term cycle must drop the result.
    send4(12'd5);
    send4(12'd5);
    send4(12'd5);
    bus4.clear = 1'b1;
    send4(12'd5);
    bus4.clear = 1'b0;
    checks++;
    if (bus4.sum_valid !== 1'b0 || bus4.sum_out !== 14'd10 || bus4.element_count !== 2'd0) begin
      errors++;
      $display("FAIL clear_last_term: valid=%b sum=%0d cnt=%0d, expected valid=0 sum=10 cnt=0",
               bus4.sum_valid, bus4.sum_out, bus4.element_count);
    end
  endtask

  task automatic test_overflow();
    send2(12'd3000);
    checks++;
    if (bus2.element_count !== 1'd1 || bus2.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_first: cnt=%0d ovf=%b, expected cnt=1 ovf=0",
               bus2.element_count, bus2.overflow);
    end
    send2(12'd3000);
    checks++;
    if (bus2.sum_valid !== 1'b1 || bus2.sum_out !== EXP_OVF_SUM || bus2.overflow !== EXP_OVF_FLAG) begin
      errors++;
      $display("FAIL ovf_result: valid=%b sum=%0d ovf=%b, expected valid=1 sum=%0d ovf=%b",
               bus2.sum_valid, bus2.sum_out, bus2.overflow, EXP_OVF_SUM, EXP_OVF_FLAG);
    end
    tick();
    checks++;
    if (bus2.overflow !== EXP_OVF_FLAG) begin
      errors++;
      $display("FAIL ovf_sticky: ovf=%b, expected %b", bus2.overflow, EXP_OVF_FLAG);
    end
    send2(12'd7);
    checks++;
    if (bus2.overflow !== 1'b0 || bus2.element_count !== 1'd1) begin
      errors++;
      $display("FAIL ovf_cleared_on_load: ovf=%b cnt=%0d, expected ovf=0 cnt=1",
               bus2.overflow, bus2.element_count);
    end
    send2(12'd9);
    checks++;
    if (bus2.sum_valid !== 1'b1 || bus2.sum_out !== 12'd16 || bus2.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_next_vector: valid=%b sum=%0d ovf=%b, expected valid=1 sum=16 ovf=0",
               bus2.sum_valid, bus2.sum_out, bus2.overflow);
    end
  endtask

  task automatic test_reset_mid();
    send4(12'd1);
    send4(12'd2);
    reset              = 1'b1;
    bus4.product_in    = 12'd9;
    bus4.product_valid = 1'b1;
    tick();
    reset              = 1'b0;
    bus4.product_valid = 1'b0;
    checks++;
    if (bus4.sum_out !== 14'd0 || bus4.sum_valid !== 1'b0 ||
        bus4.element_count !== 2'd0 || bus4.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: sum=%0d valid=%b cnt=%0d ovf=%b, expected all 0",
               bus4.sum_out, bus4.sum_valid, bus4.element_count, bus4.overflow);
    end
    for (int i = 0; i < 4; i++) send4(12'd1);
    checks++;
    if (bus4.sum_valid !== 1'b1 || bus4.sum_out !== 14'd4) begin
      errors++;
      $display("FAIL reset_mid_result: valid=%b sum=%0d, expected valid=1 sum=4",
               bus4.sum_valid, bus4.sum_out);
    end
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    reset              = 1'b1;
    bus4.product_in    = '0;
    bus4.product_valid = 1'b0;
    bus4.clear         = 1'b0;
    bus2.product_in    = '0;
    bus2.product_valid = 1'b0;
    bus2.clear         = 1'b0;

    test_reset();
    test_contiguous();
    test_gaps();
    test_back_to_back();
    test_clear();
    test_overflow();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
